// File: rtl/flash_phy_rsp.sv
// flash_phy_rsp: behavioural flash-physical responder.
// Accepts one gated operation (read / program / page erase / bank erase) at a
// time. Each operation completes with a single-cycle done pulse after its
// configured latency. The array has flash semantics: erase sets every bit to
// 1, and program can only clear bits.
// Optional build macro FLASH_PHY_RSP_PROG_CHK_EN: reject programming of a word
// that is not fully erased. The array is left unchanged, and err_o pulses
// together with prog_done_o.
module flash_phy_rsp #(
  parameter int NumBanks      = 2,
  parameter int PagesPerBank  = 4,
  parameter int WordsPerPage  = 4,
  parameter int DataW         = 32,
  parameter int RdCycles      = 2,
  parameter int ProgCycles    = 8,
  parameter int PgEraseCycles = 16,
  parameter int BkEraseCycles = 32,
  localparam int BankW = (NumBanks > 1) ? $clog2(NumBanks) : 1,
  localparam int PageW = (PagesPerBank > 1) ? $clog2(PagesPerBank) : 1,
  localparam int WordW = (WordsPerPage > 1) ? $clog2(WordsPerPage) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             rd_i,
  input  logic             prog_i,
  input  logic             pg_erase_i,
  input  logic             bk_erase_i,
  input  logic [BankW-1:0] bank_i,
  input  logic [PageW-1:0] page_i,
  input  logic [WordW-1:0] word_i,
  input  logic [DataW-1:0] prog_data_i,
  output logic [DataW-1:0] rd_data_o,
  output logic             rd_done_o,
  output logic             prog_done_o,
  output logic             erase_done_o,
  output logic             err_o,
  output logic             busy_o
);

  localparam int Depth  = NumBanks * PagesPerBank * WordsPerPage;
  localparam int IdxW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int MaxA   = (RdCycles > ProgCycles) ? RdCycles : ProgCycles;
  localparam int MaxB   = (PgEraseCycles > BkEraseCycles) ? PgEraseCycles : BkEraseCycles;
  localparam int MaxLat = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int CntW   = $clog2(MaxLat + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2,
    S_REARM = 2'd3
  } state_t;

  localparam logic [1:0] OP_RD   = 2'd0;
  localparam logic [1:0] OP_PROG = 2'd1;
  localparam logic [1:0] OP_PE   = 2'd2;
  localparam logic [1:0] OP_BE   = 2'd3;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_op;
  logic [BankW-1:0] r_bank;
  logic [PageW-1:0] r_page;
  logic [WordW-1:0] r_word;
  logic [DataW-1:0] r_data;
  logic [CntW-1:0]  r_cnt;
  logic [DataW-1:0] r_mem [Depth];

  logic [3:0]       w_strb;
  logic             w_legal;
  logic             w_accept;
  logic             w_fire;
  logic             w_prog_rej;
  logic [1:0]       w_op_in;
  logic [CntW-1:0]  w_lat_ld;
  logic [IdxW-1:0]  w_idx;
  logic [Depth-1:0] w_erase_mask;
  logic             w_rd_done_nxt;
  logic             w_prog_done_nxt;
  logic             w_erase_done_nxt;
  logic             w_err_nxt;
  logic             w_busy_nxt;

  assign w_strb   = {rd_i, prog_i, pg_erase_i, bk_erase_i};
  // Exactly one strobe, and the bank must exist.
  assign w_legal  = (w_strb != 4'd0) && ((w_strb & (w_strb - 4'd1)) == 4'd0) &&
                    (int'(bank_i) < NumBanks);
  assign w_accept = (r_state == S_IDLE) && req_i && w_legal;
  // The array action happens on the last BUSY cycle.
  assign w_fire   = (r_state == S_BUSY) && (r_cnt == '0);
  assign w_idx    = IdxW'((int'(r_bank) * PagesPerBank + int'(r_page)) * WordsPerPage +
                          int'(r_word));

`ifdef FLASH_PHY_RSP_PROG_CHK_EN
  assign w_prog_rej = (r_op == OP_PROG) && (r_mem[w_idx] != {DataW{1'b1}});
`else
  assign w_prog_rej = 1'b0;
`endif

  // Decode the incoming strobe into an opcode and its counter preload.
  always_comb begin
    w_op_in  = OP_RD;
    w_lat_ld = CntW'(RdCycles - 1);
    if (prog_i) begin
      w_op_in  = OP_PROG;
      w_lat_ld = CntW'(ProgCycles - 1);
    end else if (pg_erase_i) begin
      w_op_in  = OP_PE;
      w_lat_ld = CntW'(PgEraseCycles - 1);
    end else if (bk_erase_i) begin
      w_op_in  = OP_BE;
      w_lat_ld = CntW'(BkEraseCycles - 1);
    end else begin
      w_op_in  = OP_RD;
      w_lat_ld = CntW'(RdCycles - 1);
    end
  end

  // Select the words cleared by a page or bank erase.
  always_comb begin
    w_erase_mask = '0;
    for (int i = 0; i < Depth; i++) begin
      if (w_fire && (r_op == OP_BE)) begin
        w_erase_mask[i] = ((i / (PagesPerBank * WordsPerPage)) == int'(r_bank));
      end else if (w_fire && (r_op == OP_PE)) begin
        w_erase_mask[i] = ((i / WordsPerPage) == (int'(r_bank) * PagesPerBank + int'(r_page)));
      end else begin
        w_erase_mask[i] = 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          w_state_nxt = w_legal ? S_BUSY : S_REARM;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_DONE: w_state_nxt = S_REARM;
      S_REARM: begin
        if (!req_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_REARM;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_rd_done_nxt    = w_fire && (r_op == OP_RD);
    w_prog_done_nxt  = w_fire && (r_op == OP_PROG);
    w_erase_done_nxt = w_fire && ((r_op == OP_PE) || (r_op == OP_BE));
    w_err_nxt        = ((r_state == S_IDLE) && req_i && !w_legal) || (w_fire && w_prog_rej);
    w_busy_nxt       = (w_state_nxt == S_BUSY) || (w_state_nxt == S_DONE);
  end

  // Output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_done_o    <= 1'b0;
      prog_done_o  <= 1'b0;
      erase_done_o <= 1'b0;
      err_o        <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      rd_done_o    <= w_rd_done_nxt;
      prog_done_o  <= w_prog_done_nxt;
      erase_done_o <= w_erase_done_nxt;
      err_o        <= w_err_nxt;
      busy_o       <= w_busy_nxt;
    end
  end

  // Operand latch at acceptance and latency countdown while busy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op   <= OP_RD;
      r_bank <= '0;
      r_page <= '0;
      r_word <= '0;
      r_data <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_op   <= w_op_in;
      r_bank <= bank_i;
      r_page <= page_i;
      r_word <= word_i;
      r_data <= prog_data_i;
      r_cnt  <= w_lat_ld;
    end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CntW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Array update and read-data capture on the final busy cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_o <= '0;
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= {DataW{1'b1}};
      end
    end else if (w_fire) begin
      if (r_op == OP_RD) begin
        rd_data_o <= r_mem[w_idx];
      end
      if ((r_op == OP_PROG) && !w_prog_rej) begin
        r_mem[w_idx] <= r_mem[w_idx] & r_data;
      end
      for (int i = 0; i < Depth; i++) begin
        if (w_erase_mask[i]) begin
          r_mem[i] <= {DataW{1'b1}};
        end
      end
    end
  end

endmodule

// File: doc/flash_phy_rsp.md
Name: flash_phy_rsp

Overview:
- Behavioural flash-physical responder on the downstream side of the flash memory-protection gate.
- Consumes the gated request strobes (req/rd/prog/pg_erase/bk_erase) and returns single-cycle done pulses after per-operation latencies.
- Holds a small word array with real flash semantics: erase sets bits to 1, program can only clear bits.
- Used as the flash endpoint in block-level and top-level simulation, and as a stand-in macro in synthesis trials.

Parameters:
- NumBanks, 2, number of banks.
- PagesPerBank, 4, pages per bank.
- WordsPerPage, 4, words per page.
- DataW, 32, word width.
- RdCycles, 2, read latency from acceptance to rd_done_o (min 1).
- ProgCycles, 8, program latency (min 1).
- PgEraseCycles, 16, page-erase latency (min 1).
- BkEraseCycles, 32, bank-erase latency (min 1).
- Derived widths: BankW=$clog2(NumBanks), PageW=$clog2(PagesPerBank), WordW=$clog2(WordsPerPage).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_i  in  1  operation request; held high by the requester until the matching done pulse.
- rd_i  in  1  read strobe.
- prog_i  in  1  program strobe.
- pg_erase_i  in  1  page-erase strobe.
- bk_erase_i  in  1  bank-erase strobe.
- bank_i  in  BankW  target bank.
- page_i  in  PageW  target page within the bank.
- word_i  in  WordW  target word within the page; ignored for erases.
- prog_data_i  in  DataW  program data.
- rd_data_o  out  DataW  read data; valid from the rd_done_o cycle and held until the next read completes.
- rd_done_o  out  1  one-cycle read completion pulse.
- prog_done_o  out  1  one-cycle program completion pulse.
- erase_done_o  out  1  one-cycle completion pulse for page or bank erase.
- err_o  out  1  one-cycle illegal-request pulse.
- busy_o  out  1  high from acceptance through the done cycle.

Behaviour:
- Reset: all outputs 0, rd_data_o 0, FSM in IDLE, counter 0, every array word set to all ones (erased). A reset asserted mid-operation aborts the operation: no done pulse is issued and no array update occurs.
- FSM states: IDLE, BUSY, DONE, REARM.
- IDLE:
  - req_i high with exactly one strobe set: latch operation, bank, page, word and data; load counter with the operation's latency minus 1; go to BUSY. busy_o is registered and rises in the following cycle.
  - req_i high with zero or more than one strobe set: pulse err_o next cycle; go to REARM.
  - req_i low: stay in IDLE.
- BUSY: decrement the counter each cycle. At 0, perform the array action and go to DONE.
- DONE: assert the done output for the latched operation for exactly one cycle, then go to REARM. Done appears exactly N cycles after the acceptance edge, where N is the operation's latency.
- REARM: wait for req_i low for at least one cycle, then return to IDLE. A request held high across completion is never re-executed. Minimum gap between operations is therefore 2 cycles after done.
- Strobe changes during BUSY are ignored; all operands are latched at acceptance.
- Array actions:
  - read: rd_data_o <= mem[bank][page][word].
  - program: mem <= mem & prog_data_i (bitwise AND).
  - page erase: all words of the addressed page <= all ones.
  - bank erase: all words of the addressed bank <= all ones.
- Address arithmetic: linear index = ((bank*PagesPerBank)+page)*WordsPerPage + word. A bank_i value >= NumBanks is treated as an illegal request: err_o pulses and the FSM goes to REARM.
- err_o and the done outputs are mutually exclusive in any cycle.

Optional Feature:
- Macro: FLASH_PHY_RSP_PROG_CHK_EN.
- Defined: programming a word that is not all ones is rejected. The array is unchanged, prog_done_o still pulses, and err_o pulses in the same cycle. This is the only case where err_o and a done output coincide.
- Undefined: no check; the AND program proceeds silently.

Test Plan:
- Reset, then read bank 1 page 3 word 2 -> rd_done_o exactly 2 cycles after acceptance, rd_data_o=32'hFFFF_FFFF.
- Program 32'h1234_5678 to bank 0 page 0 word 1, then program 32'hFFFF_00FF, then read -> rd_data_o=32'h1234_0078; prog_done_o lands 8 cycles after each acceptance.
- Program words in pages 0 and 1, page-erase page 0 -> erase_done_o at cycle 16; page 0 words read FFFF_FFFF, page 1 words unchanged. Bank-erase bank 0 -> done at cycle 32, every word in bank 0 erased.
- req_i with rd_i and prog_i both high -> err_o single pulse, no done pulse, array unchanged. req_i held high after a read's done -> no second rd_done_o until req_i drops for one cycle.
- Assert rst_i during BUSY of a program -> no prog_done_o, word reads FFFF_FFFF after reset.
- With FLASH_PHY_RSP_PROG_CHK_EN defined: program 0, then program 0 again -> second operation shows prog_done_o and err_o in the same cycle, array unchanged.
